// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester FIFO-order arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/queue_arbiter_id_fifo.sv
// Four-entry circular FIFO of requester IDs; head is visible combinationally
// so the arbiter can decide on the popped entry in the same cycle.
module id_fifo
    import arb_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic [2:0]      count
);

    logic [ID_W-1:0] mem_reg [N_REQ];
    logic [ID_W-1:0] wr_ptr_reg;
    logic [ID_W-1:0] rd_ptr_reg;
    logic [2:0]      count_reg;

    // Pointers are ID_W wide, so they wrap modulo the depth for free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_id;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/queue_arbiter.sv
// Arrival-order arbiter: requesters queue their IDs once each, the head is
// granted exclusively until release, request drop or hold-time expiry.
module queue_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] release_strobe,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             timeout,
    output logic [2:0]       queue_count
);

    state_t            state_reg;
    logic [N_REQ-1:0]  grant_reg;
    logic [ID_W-1:0]   grant_id_reg;
    logic              busy_reg;
    logic              timeout_reg;
    logic [CNT_W-1:0]  hold_cnt_reg;
    logic [N_REQ-1:0]  inq_reg;
    logic [N_REQ-1:0]  inq_next;

    logic [N_REQ-1:0]  eligible;
    logic [ID_W-1:0]   cand_id;
    logic              push;
    logic              pop;
    logic [ID_W-1:0]   fifo_head;
    logic [2:0]        fifo_count;
    logic              hold_limit;
    logic              owner_exit;

    // The current owner is excluded so it cannot queue behind itself.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
            assign eligible[gi] = req[gi] && !inq_reg[gi]
                               && !(state_reg == GRANT && grant_id_reg == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        cand_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_id = ID_W'(i);
            end
        end
    end

    assign push = |eligible;
    assign pop  = (state_reg == IDLE) && (fifo_count != 3'd0);

    id_fifo u_id_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .push_id (cand_id),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    // Pop and push never touch the same flag: the head is already queued.
    always_comb begin
        inq_next = inq_reg;
        if (pop) begin
            inq_next[fifo_head] = 1'b0;
        end
        if (push) begin
            inq_next[cand_id] = 1'b1;
        end
    end

    assign hold_limit = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
    assign owner_exit = release_strobe[grant_id_reg] || !req[grant_id_reg] || hold_limit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            inq_reg      <= '0;
        end else begin
            inq_reg     <= inq_next;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A withdrawn head is simply discarded; we stay in IDLE.
                    if (pop && req[fifo_head]) begin
                        state_reg    <= GRANT;
                        grant_reg    <= onehot4(fifo_head);
                        grant_id_reg <= fifo_head;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= '0;
                    end
                end
                GRANT: begin
                    if (owner_exit) begin
                        state_reg    <= GAP;
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        busy_reg     <= 1'b0;
                        timeout_reg  <= hold_limit;
                        hold_cnt_reg <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = busy_reg;
    assign timeout     = timeout_reg;
    assign queue_count = fifo_count;

endmodule

// File: tb/tb_queue_arbiter.sv
// Self-checking bench for queue_arbiter: directed scenarios plus a long random
// run, all compared against a queue-based behavioural model.
module tb_queue_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] release_strobe;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    logic [2:0] queue_count;

    int errors = 0;
    int checks = 0;
    bit verbose = 1'b1;

    always #5 clock = ~clock;

    queue_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req            (req),
        .release_strobe (release_strobe),
        .grant          (grant),
        .grant_id       (grant_id),
        .busy           (busy),
        .timeout        (timeout),
        .queue_count    (queue_count)
    );

    wire [10:0] dut_vec = {grant, grant_id, busy, timeout, queue_count};

    // Behavioural model: arrival queue, current owner, cycles held, gap flag.
    int mq[$];
    int m_owner   = -1;
    int m_dur     = 0;
    bit m_gap     = 1'b0;
    bit m_timeout = 1'b0;
    bit m_new     = 1'b0;

    function automatic void model_reset();
        mq.delete();
        m_owner   = -1;
        m_dur     = 0;
        m_gap     = 1'b0;
        m_timeout = 1'b0;
        m_new     = 1'b0;
    endfunction

    function automatic bit queued(int id);
        foreach (mq[k]) if (mq[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(logic [3:0] r, logic [3:0] rel);
        int cand = -1;
        int h;
        for (int i = 3; i >= 0; i--) begin
            if (r[i] && !queued(i) && i != m_owner) cand = i;
        end
        m_timeout = 1'b0;
        m_new     = 1'b0;
        if (m_owner >= 0) begin
            m_dur++;
            if (rel[m_owner] || !r[m_owner] || m_dur == MAX_HOLD) begin
                m_timeout = (m_dur == MAX_HOLD);
                m_owner   = -1;
                m_gap     = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (r[h]) begin
                m_owner = h;
                m_dur   = 0;
                m_new   = 1'b1;
            end
        end
        if (cand >= 0) mq.push_back(cand);
    endfunction

    function automatic logic [10:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        int o;
        g  = '0;
        id = '0;
        o  = m_owner;
        if (o >= 0) begin
            g[o] = 1'b1;
            id   = o[1:0];
        end
        return {g, id, (o >= 0), m_timeout, 3'(mq.size())};
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_step(req, release_strobe);
        #1;
        if (verbose && m_new) $display("grant id=%0d at %0t", m_owner, $time);
    endtask

    task automatic settle();
        req            = 4'b0000;
        release_strobe = 4'b0000;
        repeat (14) begin
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL settle_model: got %b want %b", dut_vec, model_out());
            end
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        req            = 4'b0000;
        release_strobe = 4'b0000;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dut_vec !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", dut_vec, 11'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL reset_idle: got %b want %b", dut_vec, model_out());
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] expg [8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
        req = 4'b0001;
        for (int c = 2; c <= 9; c++) begin
            release_strobe = (c - 1 == 5) ? 4'b0001 : 4'b0000;
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL single_model c%0d: got %b want %b", c, dut_vec, model_out());
            end
            checks++;
            if (grant !== expg[c-2]) begin
                errors++;
                $display("FAIL single_grant c%0d: got %b want %b", c, grant, expg[c-2]);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic [3:0] prev_g = 4'b0000;
        logic [3:0] starts[$];
        int         lens[$];
        int         run = 0;
        logic [3:0] want [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            release_strobe = (grant != 4'b0000 && grant == prev_g) ? grant : 4'b0000;
            prev_g = grant;
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL simul_model c%0d: got %b want %b", c, dut_vec, model_out());
            end
            if (grant != 4'b0000) begin
                if (run == 0) starts.push_back(grant);
                run++;
            end else if (run != 0) begin
                lens.push_back(run);
                run = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= starts.size() || k >= lens.size()) begin
                errors++;
                $display("FAIL simul_missing grant %0d: got %0d grants want 4", k, starts.size());
            end else if (starts[k] !== want[k] || lens[k] != 2) begin
                errors++;
                $display("FAIL simul_order %0d: got %b len %0d want %b len 2",
                         k, starts[k], lens[k], want[k]);
            end
        end
        settle();
    endtask

    task automatic test_timeout();
        int  held = 0;
        int  touts = 0;
        bit  dropped = 1'b0;
        bit  tout_at_drop = 1'b0;
        req            = 4'b0100;
        release_strobe = 4'b0000;
        for (int c = 0; c < 14; c++) begin
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL timeout_model c%0d: got %b want %b", c, dut_vec, model_out());
            end
            if (timeout === 1'b1) touts++;
            if (!dropped && grant == 4'b0100) held++;
            if (!dropped && held > 0 && grant == 4'b0000) begin
                dropped      = 1'b1;
                tout_at_drop = (timeout === 1'b1);
            end
        end
        checks++;
        if (held != MAX_HOLD) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles want %0d", held, MAX_HOLD);
        end
        checks++;
        if (touts != 1 || !tout_at_drop) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d pulses at_drop=%0b want 1 at_drop=1",
                     touts, tout_at_drop);
        end
        settle();
    endtask

    task automatic test_withdrawn();
        bit saw_g1 = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            req            = (c - 1 <= 2) ? 4'b0011 : ((c - 1 <= 6) ? 4'b0001 : 4'b0000);
            release_strobe = (c - 1 == 5) ? 4'b0001 : 4'b0000;
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL withdrawn_model c%0d: got %b want %b", c, dut_vec, model_out());
            end
            if (grant == 4'b0010) saw_g1 = 1'b1;
        end
        checks++;
        if (saw_g1 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL withdrawn_result: got saw_g1=%0b count=%0d want saw_g1=0 count=0",
                     saw_g1, queue_count);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        req = 4'b1000;
        while (grant !== 4'b1000 && guard < 10) begin
            cycle();
            guard++;
        end
        req = 4'b1011;
        repeat (2) cycle();
        checks++;
        if (grant !== 4'b1000 || queue_count !== 3'd2 || dut_vec !== model_out()) begin
            errors++;
            $display("FAIL midreset_setup: got grant=%b count=%0d want grant=1000 count=2",
                     grant, queue_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 11'd0) begin
            errors++;
            $display("FAIL midreset_async: got %b want %b", dut_vec, 11'd0);
        end
        model_reset();
        req = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) begin
            cycle();
            checks++;
            if (dut_vec !== model_out() || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle: got %b want %b", dut_vec, model_out());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] prev_g = 4'b0000;
        verbose = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            release_strobe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            prev_g = grant;
            cycle();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL random_model c%0d: got %b want %b", c, dut_vec, model_out());
            end
            checks++;
            if (!$onehot0(grant) || busy !== (grant != 4'b0000)) begin
                errors++;
                $display("FAIL random_onehot c%0d: got grant=%b busy=%b", c, grant, busy);
            end
            checks++;
            if (prev_g != 4'b0000 && grant != 4'b0000 && grant != prev_g) begin
                errors++;
                $display("FAIL random_gap c%0d: got %b after %b want 0000 between", c, grant, prev_g);
            end
        end
        verbose = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_withdrawn();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
